// File: rtl/axi_lite_master_drv.sv
// rtl/axi_lite_master_drv.sv - AXI4-Lite master driver with command FIFO and response port
// Optional watchdog compiled in with `define AXI_DRV_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module axi_lite_master_drv #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_cmd_valid,
  output logic                             o_cmd_ready,
  input  logic                             i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]            i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]            i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          i_cmd_wstrb,
  output logic [$clog2(CMD_DEPTH+1)-1:0]   o_cmd_count,
  output logic                             o_rsp_valid,
  input  logic                             i_rsp_ready,
  output logic                             o_rsp_write,
  output logic [DATA_WIDTH-1:0]            o_rsp_rdata,
  output logic [1:0]                       o_rsp_resp,
  output logic                             o_rsp_timeout,
  output logic                             o_busy,
  output logic [ADDR_WIDTH-1:0]            o_awaddr,
  output logic                             o_awvalid,
  input  logic                             i_awready,
  output logic [DATA_WIDTH-1:0]            o_wdata,
  output logic [DATA_WIDTH/8-1:0]          o_wstrb,
  output logic                             o_wvalid,
  input  logic                             i_wready,
  input  logic [1:0]                       i_bresp,
  input  logic                             i_bvalid,
  output logic                             o_bready,
  output logic [ADDR_WIDTH-1:0]            o_araddr,
  output logic                             o_arvalid,
  input  logic                             i_arready,
  input  logic [DATA_WIDTH-1:0]            i_rdata,
  input  logic [1:0]                       i_rresp,
  input  logic                             i_rvalid,
  output logic                             o_rready
);

  localparam int CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int PTR_W = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic                    write;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_RESP
  } state_t;

  cmd_t             r_mem [CMD_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  cmd_t             w_head;

  state_t                r_state;
  state_t                w_state_nxt;
  cmd_t                  r_cmd;
  cmd_t                  w_cmd_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]            r_rsp_resp, w_rsp_resp_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;
  logic                  w_expired;

  // No bypass: a full FIFO refuses a push even while the head is popped.
  assign w_full      = (r_count == CNT_W'(CMD_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = i_cmd_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign o_cmd_ready = !w_full;
  assign o_cmd_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{write: i_cmd_write, addr: i_cmd_addr,
                           wdata: i_cmd_wdata, wstrb: i_cmd_wstrb};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef AXI_DRV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_active;

  assign w_active  = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                     (r_state == S_RD_REQ) || (r_state == S_RD_DATA);
  assign w_expired = (r_tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_pop) begin
      r_tmo_cnt <= '0;
    end else if (w_active && (r_tmo_cnt != TMO_W'(TIMEOUT_CYCLES))) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cmd         <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd         <= w_cmd_nxt;
      r_awvalid     <= w_awvalid_nxt;
      r_wvalid      <= w_wvalid_nxt;
      r_arvalid     <= w_arvalid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_resp    <= w_rsp_resp_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cmd_nxt         = r_cmd;
    w_awvalid_nxt     = r_awvalid;
    w_wvalid_nxt      = r_wvalid;
    w_arvalid_nxt     = r_arvalid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_resp_nxt    = r_rsp_resp;
    w_rsp_timeout_nxt = r_rsp_timeout;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_cmd_nxt         = w_head;
          w_rsp_timeout_nxt = 1'b0;
          if (w_head.write) begin
            w_state_nxt   = S_WR_REQ;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_RD_REQ;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        if (i_awready) w_awvalid_nxt = 1'b0;
        if (i_wready)  w_wvalid_nxt  = 1'b0;
        if ((!r_awvalid || i_awready) && (!r_wvalid || i_wready)) begin
          w_state_nxt = S_WR_RESP;
        end else if (w_expired) begin
          w_state_nxt = S_RESP;
        end
      end
      S_WR_RESP: begin
        if (i_bvalid) begin
          w_rsp_resp_nxt  = i_bresp;
          w_rsp_rdata_nxt = '0;
          w_state_nxt     = S_RESP;
        end else if (w_expired) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RD_REQ: begin
        if (i_arready) begin
          w_arvalid_nxt = 1'b0;
          w_state_nxt   = S_RD_DATA;
        end else if (w_expired) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RD_DATA: begin
        if (i_rvalid) begin
          w_rsp_resp_nxt  = i_rresp;
          w_rsp_rdata_nxt = i_rdata;
          w_state_nxt     = S_RESP;
        end else if (w_expired) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Watchdog abort: only reached when no completing handshake happened this cycle.
    if ((r_state != S_IDLE) && (r_state != S_RESP) && (w_state_nxt == S_RESP) &&
        !(r_state == S_WR_RESP && i_bvalid) && !(r_state == S_RD_DATA && i_rvalid)) begin
      w_awvalid_nxt     = 1'b0;
      w_wvalid_nxt      = 1'b0;
      w_arvalid_nxt     = 1'b0;
      w_rsp_resp_nxt    = 2'b10;
      w_rsp_rdata_nxt   = '0;
      w_rsp_timeout_nxt = 1'b1;
    end
  end

  assign o_awaddr      = r_cmd.addr;
  assign o_araddr      = r_cmd.addr;
  assign o_wdata       = r_cmd.wdata;
  assign o_wstrb       = r_cmd.wstrb;
  assign o_awvalid     = r_awvalid;
  assign o_wvalid      = r_wvalid;
  assign o_arvalid     = r_arvalid;
  assign o_bready      = (r_state == S_WR_RESP);
  assign o_rready      = (r_state == S_RD_DATA);
  assign o_rsp_valid   = (r_state == S_RESP);
  assign o_rsp_write   = r_cmd.write;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_resp    = r_rsp_resp;
  assign o_rsp_timeout = r_rsp_timeout;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_axi_lite_master_drv.sv
// tb/tb_axi_lite_master_drv.sv - directed self-checking bench for axi_lite_master_drv
// Timeout sequence is built only with `define AXI_DRV_TIMEOUT_EN (TIMEOUT_CYCLES=16).
module tb_axi_lite_master_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [2:0]  cmd_count;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata, last_ar, w_rdata;
  logic        use_echo;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ECHO_K = 32'hA5A5_0000;

  always #5 clk = ~clk;

  always @(posedge clk) if (arvalid && s_arready) last_ar <= araddr;
  assign w_rdata = use_echo ? (last_ar ^ ECHO_K) : s_rdata;

  axi_lite_master_drv #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_cmd_count(cmd_count),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout),
    .o_busy(busy),
    .o_awaddr(awaddr), .o_awvalid(awvalid), .i_awready(s_awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(s_wready),
    .i_bresp(s_bresp), .i_bvalid(s_bvalid), .o_bready(bready),
    .o_araddr(araddr), .o_arvalid(arvalid), .i_arready(s_arready),
    .i_rdata(w_rdata), .i_rresp(s_rresp), .i_rvalid(s_rvalid), .o_rready(rready)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  sresp;
    logic [31:0] srdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after an edge; returns 1ns after the accepting edge k.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    s_bvalid  = 1'b1; s_rvalid = 1'b1;
    s_bresp   = v.sresp; s_rresp = v.sresp; s_rdata = v.srdata;
    send(v.write, v.addr, v.wdata, v.wstrb);
    chk("k0_busy", busy, 0);
    chk("k0_count", cmd_count, 1);
    tick();
    chk("k1_awvalid", awvalid, v.write);
    chk("k1_wvalid", wvalid, v.write);
    chk("k1_arvalid", arvalid, !v.write);
    chk("k1_addr", v.write ? awaddr : araddr, v.addr);
    if (v.write) begin
      chk("k1_wdata", wdata, v.wdata);
      chk("k1_wstrb", wstrb, v.wstrb);
    end
    tick();
    chk("k2_valids", {awvalid, wvalid, arvalid}, 3'b000);
    chk("k2_bready", bready, v.write);
    chk("k2_rready", rready, !v.write);
    chk("k2_rsp_valid", rsp_valid, 0);
    tick();
    chk("k3_rsp_valid", rsp_valid, 1);
    chk("k3_rsp_write", rsp_write, v.write);
    chk("k3_rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("k3_rsp_resp", rsp_resp, v.exp_resp);
    chk("k3_rsp_timeout", rsp_timeout, 0);
    chk("k3_readys", {bready, rready}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   cnt;
    bit   done;
    bit   pend_drop;
    bit   accepted;
    int   nrsp;
    logic [31:0] got[6];

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hFFFF_FFFF, 32'h0, 2'b00};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 2'b00, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b00};
    vecs[2] = '{1'b1, 32'h0000_0024, 32'h0102_0304, 4'h3, 2'b10, 32'hFFFF_FFFF, 32'h0, 2'b10};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 2'b11, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 2'b11};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b1; use_echo = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0; s_bvalid = 1'b0; s_rvalid = 1'b0;
    s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = '0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Read with three wait states on rvalid.
    s_arready = 1'b1; s_rvalid = 1'b0; s_rresp = 2'b00; s_rdata = 32'h1234_5678;
    send(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    cnt = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (rsp_valid) done = 1'b1;
      else begin
        if (rready) cnt++;
        if (cnt == 4) s_rvalid = 1'b1;
      end
    end
    chk("rdwait_done", done, 1);
    chk("rdwait_rready_cycles", cnt, 4);
    chk("rdwait_rdata", rsp_rdata, 32'h1234_5678);
    s_rvalid = 1'b0;

    // Write where W handshakes two cycles before AW.
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b00;
    send(1'b1, 32'h0000_0030, 32'h55AA_55AA, 4'hF);
    tick();
    chk("wfirst_k1", {awvalid, wvalid}, 2'b11);
    s_wready = 1'b1;
    tick();
    chk("wfirst_k2", {awvalid, wvalid}, 2'b10);
    s_wready = 1'b0;
    tick();
    chk("wfirst_k3", {awvalid, wvalid, bready}, 3'b100);
    s_awready = 1'b1;
    tick();
    chk("wfirst_k4", {awvalid, bready}, 2'b01);
    tick();
    chk("wfirst_k5", {rsp_valid, bready, rsp_write}, 3'b101);
    s_awready = 1'b1; s_wready = 1'b1;

    // FIFO fill with AR stalled; reads echo their address so order is visible.
    use_echo = 1'b1; s_arready = 1'b0; s_rvalid = 1'b1; s_rresp = 2'b00;
    send(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    tick();
    for (int i = 1; i <= 4; i++) send(1'b0, 32'h0000_0100 + 32'(4 * i), 32'h0, 4'h0);
    chk("fifo_full_count", cmd_count, 4);
    chk("fifo_full_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0114;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fifo_refuse", {cmd_ready, cmd_count}, {1'b0, 3'd4});
    end
    s_arready = 1'b1;
    nrsp = 0; pend_drop = 1'b0; accepted = 1'b0;
    for (int c = 0; c < 80 && nrsp < 6; c++) begin
      tick();
      if (pend_drop) begin
        cmd_valid = 1'b0;
        pend_drop = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        chk("fifo_accept_count", cmd_count, 3);
        pend_drop = 1'b1;
        accepted  = 1'b1;
      end
      if (rsp_valid) begin
        got[nrsp] = rsp_rdata;
        nrsp++;
      end
    end
    cmd_valid = 1'b0;
    chk("fifo_fifth_accepted", accepted, 1);
    chk("fifo_rsp_count", nrsp, 6);
    for (int i = 0; i < 6; i++) chk("fifo_order", got[i], (32'h0000_0100 + 32'(4 * i)) ^ ECHO_K);
    use_echo = 1'b0;
    tick();

    // Asynchronous reset during WR_RESP with one command still queued.
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
    send(1'b1, 32'h0000_0050, 32'h1111_2222, 4'hF);
    tick();
    tick();
    chk("rstmid_bready", bready, 1);
    send(1'b1, 32'h0000_0060, 32'h3333_4444, 4'hF);
    chk("rstmid_queued", cmd_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy}, 7'b0);
    chk("rstmid_addr_data", {awaddr, wdata, araddr}, 96'h0);
    chk("rstmid_rsp", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
    chk("rstmid_count", cmd_count, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    tick();
    chk("rstmid_idle_after", {busy, cmd_count}, 4'b0);
    run_vec(vecs[0]);

`ifdef AXI_DRV_TIMEOUT_EN
    s_awready = 1'b0; s_wready = 1'b1; s_bvalid = 1'b1;
    send(1'b1, 32'h0000_0070, 32'h7777_7777, 4'hF);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!awvalid) break;
      cnt++;
    end
    chk("tmo_awvalid_cycles", cnt, 16);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_flag", rsp_timeout, 1);
    chk("tmo_resp", rsp_resp, 2'b10);
    chk("tmo_rdata", rsp_rdata, 0);
    s_awready = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
